dot_req_master: RTL and testbench
=================================

DOT_REQ_MASTER -- requirements
Module: dot_req_master

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port s_valid  input  1  upstream nibble valid.
REQ-004 SHALL have port s_ready  output  1  upstream nibble accepted when s_valid&&s_ready.
REQ-005 SHALL have port s_nib  input  4  unsigned operand nibble.
REQ-006 SHALL have port s_kind  input  1  0 = input nibble, 1 = weight nibble.
REQ-007 SHALL have port in_valid  output  1  one-cycle pulse, I valid to dot engine.
REQ-008 SHALL have port weight_valid  output  1  one-cycle pulse, W valid to dot engine.
REQ-009 SHALL have ports I and W  output  128 each  packed vectors; first accepted nibble at [127:124], 32nd at [3:0].
REQ-010 SHALL have port out_valid  input  1  dot engine result strobe.
REQ-011 SHALL have port OUT  input  13  dot engine result.
REQ-012 SHALL have ports res_valid output 1, res_ready input 1, res_data output 13, res_err output 1: result handshake.
REQ-013 SHALL have port proto_err  output  1  one-cycle protocol-violation pulse.

Function
REQ-014 SHALL implement states FILL, ISSUE_W, ISSUE_I, WAIT, RESP.
REQ-015 FILL: s_ready=1. Each accepted nibble goes into the packer. The kind is latched on beat 0. Beat counter runs 0..31.
REQ-016 Mid-packet nibble with s_kind != latched kind: discard the partial packet, restart at beat 0 with this nibble as the first beat, and pulse proto_err.
REQ-017 32nd weight beat accepted at cycle T: W updated and weight_valid=1 at T+1 (ISSUE_W), then return to FILL. s_ready=0 during ISSUE_W.
REQ-018 32nd input beat accepted at cycle T: I updated and in_valid=1 at T+1 (ISSUE_I), then WAIT.
REQ-019 in_valid and weight_valid SHALL never assert in the same cycle.
REQ-020 I and W SHALL hold their last issued value until the next issue of the same kind. An input issue with no prior weight issue is allowed (W=0).
REQ-021 WAIT: s_ready=0. On out_valid=1, capture OUT into res_data, res_err=0, next state RESP.
REQ-022 out_valid in any state other than WAIT SHALL be ignored and SHALL pulse proto_err.
REQ-023 RESP: res_valid=1, res_data stable. On res_valid&&res_ready, next state FILL and res_valid=0 the following cycle.
REQ-024 Back-to-back jobs: first nibble of the next packet SHALL be accepted the cycle after the RESP handshake.

Reset
REQ-025 Reset SHALL force state FILL, beat counter 0, and all outputs 0: I, W, in_valid, weight_valid, res_valid, res_data, res_err, proto_err. s_ready=1 after release.
REQ-026 Reset mid-FILL or mid-WAIT SHALL discard the partial packet or pending result. No pulse SHALL be emitted after release.

Configuration
REQ-027 With macro DOT_REQ_TIMEOUT_EN defined, WAIT SHALL count cycles from 0 (4-bit counter). After 16 cycles with no out_valid: res_data=13'h1FFF, res_err=1, next state RESP. A late out_valid is then handled per REQ-022.
REQ-028 Without DOT_REQ_TIMEOUT_EN, WAIT SHALL persist until out_valid, no timeout counter SHALL exist, and res_err SHALL be constant 0.

Structure
REQ-029 Package dot_pkg SHALL hold NIB_W=4, LANES=32, VEC_W=128, OUT_W=13, TIMEOUT_CYC=16, and the state enum.
REQ-030 Sub-module dot_nib_packer SHALL contain the 128-bit shift packer, beat counter, kind latch and mismatch detect. It is instantiated once and shared by I and W.

Verification
REQ-031 32 weight nibbles 4'h1, then 32 input nibbles 4'h2, model returns OUT=64 -> W=128'h1111...1, I=128'h2222...2, single pulses on weight_valid then in_valid, res_data=64, res_err=0.
REQ-032 All nibbles 4'hF for both packets, OUT=7200 -> res_data=7200. Hold res_ready=0 for 10 cycles -> res_valid and res_data stable, s_ready=0 throughout.
REQ-033 10 input nibbles, then a weight nibble -> proto_err pulses once. 32 further weight nibbles (counting the switching nibble as beat 0) -> exactly one weight_valid pulse, with the switching nibble at W[127:124].
REQ-034 DOT_REQ_TIMEOUT_EN defined, engine silent after in_valid -> 16 cycles later res_valid=1, res_data=13'h1FFF, res_err=1. Then a late out_valid -> proto_err pulse.
REQ-035 rst_n low after 20 input nibbles, then 32 fresh input nibbles -> exactly one in_valid pulse, I equal to the fresh packet only, no proto_err.

Source files
------------

// File: rtl/dot_req_master_pkg.sv
// Shared constants and types for the dot-product request master.
// Optional feature macro: DOT_REQ_TIMEOUT_EN (adds the WAIT-state timeout).
package dot_pkg;

   localparam int NIB_W       = 4;
   localparam int LANES       = 32;
   localparam int VEC_W       = 128;
   localparam int OUT_W       = 13;
   localparam int TIMEOUT_CYC = 16;
   localparam int BEAT_W      = $clog2(LANES);

   typedef enum logic [2:0] {
      ST_FILL    = 3'd0,
      ST_ISSUE_W = 3'd1,
      ST_ISSUE_I = 3'd2,
      ST_WAIT    = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

endpackage

// File: rtl/dot_req_master_if.sv
// Bus bundle between the request master and its neighbours: upstream nibble
// stream, dot-engine operand/result signals, and the result handshake.
interface dot_req_master_if;
   import dot_pkg::*;

   logic                s_valid;
   logic                s_ready;
   logic [NIB_W-1:0]    s_nib;
   logic                s_kind;
   logic                in_valid;
   logic                weight_valid;
   logic [VEC_W-1:0]    I;
   logic [VEC_W-1:0]    W;
   logic                out_valid;
   logic [OUT_W-1:0]    OUT;
   logic                res_valid;
   logic                res_ready;
   logic [OUT_W-1:0]    res_data;
   logic                res_err;
   logic                proto_err;

   modport master (
      input  s_valid, s_nib, s_kind, out_valid, OUT, res_ready,
      output s_ready, in_valid, weight_valid, I, W,
             res_valid, res_data, res_err, proto_err
   );

   modport slave (
      output s_valid, s_nib, s_kind, out_valid, OUT, res_ready,
      input  s_ready, in_valid, weight_valid, I, W,
             res_valid, res_data, res_err, proto_err
   );

endinterface

// File: rtl/dot_req_master_nib_packer.sv
// Nibble packer shared by the input and weight operands: shifts accepted
// nibbles into a 128-bit vector, counts beats, latches the packet kind on
// beat 0 and flags a kind switch in the middle of a packet.
module dot_nib_packer
   import dot_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_accept,
   input  logic [NIB_W-1:0]   i_nib,
   input  logic               i_kind,
   output logic               o_done,
   output logic               o_mismatch,
   output logic [VEC_W-1:0]   o_nextVec
);

   logic [VEC_W-1:0]  r_shift;
   logic [BEAT_W-1:0] r_beat;
   logic              r_kind;

   assign o_mismatch = i_accept && (r_beat != '0) && (i_kind != r_kind);
   assign o_done     = i_accept && !o_mismatch && (r_beat == BEAT_W'(LANES-1));
   assign o_nextVec  = {r_shift[VEC_W-NIB_W-1:0], i_nib};

   // Shift in each accepted nibble; a kind switch restarts the packet with
   // the switching nibble as beat 0, so the counter jumps straight to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_beat  <= '0;
         r_kind  <= 1'b0;
      end else if (i_accept) begin
         r_shift <= o_nextVec;
         if ((r_beat == '0) || o_mismatch) begin
            r_kind <= i_kind;
         end
         if (o_mismatch) begin
            r_beat <= BEAT_W'(1);
         end else begin
            r_beat <= r_beat + BEAT_W'(1);
         end
      end
   end

endmodule

// File: rtl/dot_req_master.sv
// Dot-product request master: packs 32-nibble weight and input packets,
// issues them to the dot engine, waits for the result and offers it on a
// valid/ready handshake. Define DOT_REQ_TIMEOUT_EN to give up waiting after
// a fixed number of cycles and return an error result instead.
module dot_req_master
   import dot_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   dot_req_master_if.master   bus
);

   state_e            r_state;
   logic [VEC_W-1:0]  r_i;
   logic [VEC_W-1:0]  r_w;
   logic [OUT_W-1:0]  r_resData;
   logic              r_protoErr;

   logic              w_accept;
   logic              w_done;
   logic              w_mismatch;
   logic [VEC_W-1:0]  w_nextVec;

`ifdef DOT_REQ_TIMEOUT_EN
   logic [3:0]        r_waitCnt;
   logic              r_resErr;
   logic              w_timeout;
`endif

   assign w_accept = bus.s_valid && bus.s_ready;

   dot_nib_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_accept   (w_accept),
      .i_nib      (bus.s_nib),
      .i_kind     (bus.s_kind),
      .o_done     (w_done),
      .o_mismatch (w_mismatch),
      .o_nextVec  (w_nextVec)
   );

   assign bus.s_ready      = (r_state == ST_FILL);
   assign bus.weight_valid = (r_state == ST_ISSUE_W);
   assign bus.in_valid     = (r_state == ST_ISSUE_I);
   assign bus.res_valid    = (r_state == ST_RESP);
   assign bus.I            = r_i;
   assign bus.W            = r_w;
   assign bus.res_data     = r_resData;
   assign bus.proto_err    = r_protoErr;

`ifdef DOT_REQ_TIMEOUT_EN
   assign bus.res_err = r_resErr;
   assign w_timeout   = (r_waitCnt == 4'(TIMEOUT_CYC-1));

   // Cycle counter for WAIT; it is cleared whenever we are elsewhere so each
   // job starts counting from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waitCnt <= '0;
      end else if (r_state == ST_WAIT) begin
         r_waitCnt <= r_waitCnt + 4'd1;
      end else begin
         r_waitCnt <= '0;
      end
   end
`else
   assign bus.res_err = 1'b0;
`endif

   // Main job sequencer: issue the finished packet, wait for the engine,
   // hold the result until taken. Protocol errors are registered one-cycle
   // pulses for a kind switch mid-packet or an unexpected engine strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_FILL;
         r_i        <= '0;
         r_w        <= '0;
         r_resData  <= '0;
         r_protoErr <= 1'b0;
`ifdef DOT_REQ_TIMEOUT_EN
         r_resErr   <= 1'b0;
`endif
      end else begin
         r_protoErr <= w_mismatch || (bus.out_valid && (r_state != ST_WAIT));
         case (r_state)
            ST_FILL: begin
               if (w_done) begin
                  if (bus.s_kind) begin
                     r_w     <= w_nextVec;
                     r_state <= ST_ISSUE_W;
                  end else begin
                     r_i     <= w_nextVec;
                     r_state <= ST_ISSUE_I;
                  end
               end
            end
            ST_ISSUE_W: begin
               r_state <= ST_FILL;
            end
            ST_ISSUE_I: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.out_valid) begin
                  r_resData <= bus.OUT;
`ifdef DOT_REQ_TIMEOUT_EN
                  r_resErr  <= 1'b0;
`endif
                  r_state   <= ST_RESP;
               end
`ifdef DOT_REQ_TIMEOUT_EN
               else if (w_timeout) begin
                  r_resData <= {OUT_W{1'b1}};
                  r_resErr  <= 1'b1;
                  r_state   <= ST_RESP;
               end
`endif
            end
            ST_RESP: begin
               if (bus.res_ready) begin
                  r_state <= ST_FILL;
               end
            end
            default: begin
               r_state <= ST_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dot_req_master.sv
// Directed self-checking bench for dot_req_master. Timeout scenario is
// compiled only when DOT_REQ_TIMEOUT_EN is defined.
module tb_dot_req_master;
   import dot_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   inPulses;
   int   wPulses;
   int   perrPulses;
   int   overlaps;

   dot_req_master_if bus();

   dot_req_master dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.in_valid)     inPulses++;
         if (bus.weight_valid) wPulses++;
         if (bus.proto_err)    perrPulses++;
         if (bus.in_valid && bus.weight_valid) overlaps++;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sendNib(input logic [3:0] nib, input logic kind);
      int guard;
      guard = 0;
      bus.s_valid = 1'b1;
      bus.s_nib   = nib;
      bus.s_kind  = kind;
      while (!bus.s_ready && guard < 50) begin
         cycle();
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("[TB] FAIL s_ready_wait got=timeout exp=ready");
      end
      cycle();
      bus.s_valid = 1'b0;
   endtask

   task automatic sendPacket(input logic [3:0] first, input logic [3:0] rest,
                             input logic kind, input int count);
      for (int k = 0; k < count; k++) begin
         sendNib((k == 0) ? first : rest, kind);
      end
   endtask

   task automatic engineRespond(input logic [OUT_W-1:0] value);
      cycle();
      bus.out_valid = 1'b1;
      bus.OUT       = value;
      cycle();
      bus.out_valid = 1'b0;
      bus.OUT       = '0;
   endtask

   task automatic waitResValid(output int n);
      n = 0;
      while (!bus.res_valid && n < 60) begin
         cycle();
         n++;
      end
      if (n >= 60) begin
         checks++;
         failures++;
         $display("[TB] FAIL res_valid_wait got=timeout exp=res_valid");
      end
   endtask

   task automatic resHandshake();
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      checks++;
      if ({bus.in_valid, bus.weight_valid, bus.res_valid, bus.res_err, bus.proto_err} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL reset_strobes got=%b exp=00000",
                  {bus.in_valid, bus.weight_valid, bus.res_valid, bus.res_err, bus.proto_err});
      end
      checks++;
      if (bus.I !== '0 || bus.W !== '0) begin
         failures++;
         $display("[TB] FAIL reset_vectors got=%h/%h exp=0", bus.I, bus.W);
      end
      checks++;
      if (bus.res_data !== '0) begin
         failures++;
         $display("[TB] FAIL reset_res_data got=%0d exp=0", bus.res_data);
      end
      rst_n = 1'b1;
      cycle();
      checks++;
      if (bus.s_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_s_ready got=%b exp=1", bus.s_ready);
      end
   endtask

   task automatic test_basic();
      int w0, i0, n;
      w0 = wPulses;
      i0 = inPulses;
      sendPacket(4'h1, 4'h1, 1'b1, 32);
      checks++;
      if (bus.weight_valid !== 1'b1 || bus.s_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_issue_w got=wv%b/rdy%b exp=wv1/rdy0", bus.weight_valid, bus.s_ready);
      end
      cycle();
      checks++;
      if (wPulses - w0 != 1 || inPulses - i0 != 0) begin
         failures++;
         $display("[TB] FAIL basic_w_pulse got=w%0d/i%0d exp=w1/i0", wPulses - w0, inPulses - i0);
      end
      checks++;
      if (bus.W !== {32{4'h1}}) begin
         failures++;
         $display("[TB] FAIL basic_W got=%h exp=%h", bus.W, {32{4'h1}});
      end
      sendPacket(4'h2, 4'h2, 1'b0, 32);
      engineRespond(13'd64);
      waitResValid(n);
      checks++;
      if (inPulses - i0 != 1 || wPulses - w0 != 1) begin
         failures++;
         $display("[TB] FAIL basic_i_pulse got=i%0d/w%0d exp=i1/w1", inPulses - i0, wPulses - w0);
      end
      checks++;
      if (bus.I !== {32{4'h2}}) begin
         failures++;
         $display("[TB] FAIL basic_I got=%h exp=%h", bus.I, {32{4'h2}});
      end
      checks++;
      if (bus.res_data !== 13'd64 || bus.res_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_result got=%0d/err%b exp=64/err0", bus.res_data, bus.res_err);
      end
      resHandshake();
      checks++;
      if (bus.res_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL basic_after_hs got=rv%b/rdy%b exp=rv0/rdy1", bus.res_valid, bus.s_ready);
      end
   endtask

   task automatic test_hold();
      int n;
      sendPacket(4'hF, 4'hF, 1'b1, 32);
      sendPacket(4'hF, 4'hF, 1'b0, 32);
`ifndef DOT_REQ_TIMEOUT_EN
      for (int k = 0; k < 40; k++) cycle();
      checks++;
      if (bus.res_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL hold_wait_persist got=rv%b/rdy%b exp=rv0/rdy0", bus.res_valid, bus.s_ready);
      end
`endif
      engineRespond(13'd7200);
      waitResValid(n);
      checks++;
      if (bus.W !== {32{4'hF}} || bus.I !== {32{4'hF}}) begin
         failures++;
         $display("[TB] FAIL hold_vectors got=%h/%h exp=all F", bus.I, bus.W);
      end
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== 13'd7200 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_stable got=rv%b/%0d/rdy%b exp=rv1/7200/rdy0",
                     bus.res_valid, bus.res_data, bus.s_ready);
         end
         cycle();
      end
      resHandshake();
      checks++;
      if (bus.res_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL hold_release got=%b exp=0", bus.res_valid);
      end
   endtask

   task automatic test_mismatch();
      int w0, i0, p0;
      w0 = wPulses;
      i0 = inPulses;
      p0 = perrPulses;
      sendPacket(4'h5, 4'h5, 1'b0, 10);
      sendPacket(4'hA, 4'h3, 1'b1, 32);
      cycle();
      cycle();
      checks++;
      if (perrPulses - p0 != 1) begin
         failures++;
         $display("[TB] FAIL mismatch_proto_err got=%0d exp=1", perrPulses - p0);
      end
      checks++;
      if (wPulses - w0 != 1 || inPulses - i0 != 0) begin
         failures++;
         $display("[TB] FAIL mismatch_pulses got=w%0d/i%0d exp=w1/i0", wPulses - w0, inPulses - i0);
      end
      checks++;
      if (bus.W !== {4'hA, {31{4'h3}}}) begin
         failures++;
         $display("[TB] FAIL mismatch_W got=%h exp=%h", bus.W, {4'hA, {31{4'h3}}});
      end
   endtask

   task automatic test_late_out_valid();
      int p0;
      p0 = perrPulses;
      bus.out_valid = 1'b1;
      bus.OUT       = 13'd99;
      cycle();
      bus.out_valid = 1'b0;
      bus.OUT       = '0;
      cycle();
      checks++;
      if (perrPulses - p0 != 1) begin
         failures++;
         $display("[TB] FAIL stray_proto_err got=%0d exp=1", perrPulses - p0);
      end
      checks++;
      if (bus.res_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.res_data !== 13'd7200) begin
         failures++;
         $display("[TB] FAIL stray_ignored got=rv%b/rdy%b/%0d exp=rv0/rdy1/7200",
                  bus.res_valid, bus.s_ready, bus.res_data);
      end
   endtask

`ifdef DOT_REQ_TIMEOUT_EN
   task automatic test_timeout();
      int n, p0;
      sendPacket(4'h4, 4'h4, 1'b0, 32);
      waitResValid(n);
      checks++;
      if (n != TIMEOUT_CYC + 1) begin
         failures++;
         $display("[TB] FAIL timeout_latency got=%0d exp=%0d", n, TIMEOUT_CYC + 1);
      end
      checks++;
      if (bus.res_data !== 13'h1FFF || bus.res_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL timeout_result got=%h/err%b exp=1fff/err1", bus.res_data, bus.res_err);
      end
      p0 = perrPulses;
      bus.out_valid = 1'b1;
      bus.OUT       = 13'd5;
      cycle();
      bus.out_valid = 1'b0;
      cycle();
      checks++;
      if (perrPulses - p0 != 1 || bus.res_data !== 13'h1FFF) begin
         failures++;
         $display("[TB] FAIL timeout_late got=perr%0d/%h exp=perr1/1fff", perrPulses - p0, bus.res_data);
      end
      resHandshake();
   endtask
`endif

   task automatic test_reset_mid();
      int i0, p0, n;
      sendPacket(4'h7, 4'h7, 1'b0, 20);
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      i0 = inPulses;
      p0 = perrPulses;
      checks++;
      if (bus.W !== '0 || bus.I !== '0) begin
         failures++;
         $display("[TB] FAIL rstmid_cleared got=%h/%h exp=0", bus.I, bus.W);
      end
      sendPacket(4'h9, 4'h9, 1'b0, 32);
      engineRespond(13'd1);
      waitResValid(n);
      checks++;
      if (inPulses - i0 != 1 || perrPulses - p0 != 0) begin
         failures++;
         $display("[TB] FAIL rstmid_pulses got=i%0d/perr%0d exp=i1/perr0", inPulses - i0, perrPulses - p0);
      end
      checks++;
      if (bus.I !== {32{4'h9}}) begin
         failures++;
         $display("[TB] FAIL rstmid_I got=%h exp=%h", bus.I, {32{4'h9}});
      end
      resHandshake();
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      inPulses      = 0;
      wPulses       = 0;
      perrPulses    = 0;
      overlaps      = 0;
      rst_n         = 1'b0;
      bus.s_valid   = 1'b0;
      bus.s_nib     = '0;
      bus.s_kind    = 1'b0;
      bus.out_valid = 1'b0;
      bus.OUT       = '0;
      bus.res_ready = 1'b0;
      #2;
      test_reset();
      test_basic();
      test_hold();
      test_mismatch();
      test_late_out_valid();
`ifdef DOT_REQ_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      checks++;
      if (overlaps != 0) begin
         failures++;
         $display("[TB] FAIL issue_overlap got=%0d exp=0", overlaps);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
